// File: rtl/nios2_qsys_pio_key_if.sv
// rtl/nios2_qsys_pio_key_if.sv - Avalon-MM slave bus bundle for the key PIO
interface nios2_qsys_pio_key_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_qsys_pio_key.sv
// rtl/nios2_qsys_pio_key.sv - debounced push-button input PIO with edge capture and maskable irq
module nios2_qsys_pio_key #(
  parameter int             WIDTH           = 8,
  parameter int             DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VALUE   = 8'hFF,
  parameter int             EDGE_TYPE       = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios2_qsys_pio_key_if.slave  bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] deb_q,   deb_d;
  logic [WIDTH-1:0] mask_q,  mask_d;
  logic [WIDTH-1:0] edge_q,  edge_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] capture;
  logic             wr_en;
  logic [31:0]      rdata;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign unused_wdata = ^bus.writedata[31:WIDTH];

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    mask_d  = mask_q;
    capture = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
        if (EDGE_TYPE == 0)      capture[i] = !sync2_q[i];
        else if (EDGE_TYPE == 1) capture[i] = sync2_q[i];
        else                     capture[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    if (wr_en && bus.address == 2'd2) mask_d = bus.writedata[WIDTH-1:0];

    edge_d = edge_q;
    if (wr_en && bus.address == 2'd3) edge_d = edge_q & ~bus.writedata[WIDTH-1:0];
    // a capture in the same cycle as a clear wins, so no edge is ever lost
    edge_d = edge_d | capture;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_VALUE;
      sync2_q <= RESET_VALUE;
      deb_q   <= RESET_VALUE;
      mask_q  <= '0;
      edge_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      2'd0:    rdata[WIDTH-1:0] = deb_q;
      2'd2:    rdata[WIDTH-1:0] = mask_q;
      2'd3:    rdata[WIDTH-1:0] = edge_q;
      default: rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign irq          = |(edge_q & mask_q);

endmodule
